tape_video_encoder: RTL and testbench

- Parametrised successor to the fixed grey-level output path.
- Turns a byte stream into a line/frame-structured composite video sample stream for the VGA DAC: sync, porches and active data.
- Active data is multi-level symbols of BPS bits each, held for SYM_PIX pixel clocks.
- Sits between the data source (ethernet RX path / FIFO) and the DAC pins; runs on the NTSC pixel clock.

---
 rtl/tape_video_pkg.sv | 35 +++
 rtl/tape_symbol_shifter.sv | 61 ++++++
 rtl/tape_video_encoder.sv | 207 ++++++++++++++++++++
 tb/tb_tape_video_encoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tape_video_pkg.sv
// Shared types, default timing/level constants and the symbol-to-DAC mapping
// for the tape video encoder.
package tape_video_pkg;

    typedef enum logic [1:0] {PH_SYNC, PH_BACK, PH_ACTIVE, PH_FRONT} phase_t;
    typedef enum logic [1:0] {LT_VSYNC, LT_BLANK, LT_ACTIVE} line_type_t;
    typedef enum logic {ST_IDLE, ST_RUN} run_state_t;

    localparam int DEF_H_SYNC    = 64;
    localparam int DEF_H_BACK    = 96;
    localparam int DEF_H_ACTIVE  = 1280;
    localparam int DEF_H_FRONT   = 32;
    localparam int DEF_V_SYNC    = 3;
    localparam int DEF_V_BLANK   = 19;
    localparam int DEF_V_ACTIVE  = 240;
    localparam int DEF_BPS       = 2;
    localparam int DEF_SYM_PIX   = 2;
    localparam int DEF_BLANK_LVL = 60;
    localparam int DEF_BLACK_LVL = 70;
    localparam int DEF_STEP      = 61;

    // Header bytes at the start of each active line when LINE_HEADER_EN is defined.
    localparam int HEADER_SLOTS  = 2;

    function automatic int slot_pixels(input int bps, input int sym_pix);
        return sym_pix * (8 / bps);
    endfunction

    function automatic logic [7:0] sym_level(input logic [7:0] sym,
                                             input logic [7:0] black_lvl,
                                             input logic [7:0] step);
        return black_lvl + sym * step;
    endfunction

endpackage

// File: rtl/tape_symbol_shifter.sv
// Byte-to-symbol serializer: MSB-first symbols of BPS bits, each held SYM_PIX
// pixels; flags the last pixel of the byte slot.
module tape_symbol_shifter
    import tape_video_pkg::*;
#(
    parameter int BPS     = DEF_BPS,
    parameter int SYM_PIX = DEF_SYM_PIX
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           advance,
    input  logic [7:0]     load_byte,
    output logic [BPS-1:0] sym,
    output logic           slot_last
);

    localparam int SYMS = 8 / BPS;
    localparam int HW   = (SYM_PIX > 1) ? $clog2(SYM_PIX) : 1;
    localparam int SW   = (SYMS > 1) ? $clog2(SYMS) : 1;

    logic [7:0]    shreg;
    logic [HW-1:0] hold;
    logic [SW-1:0] sym_idx;

    logic [7:0]    cur_reg;
    logic [HW-1:0] cur_hold;
    logic [SW-1:0] cur_idx;
    logic          hold_last;
    logic          sym_last;

    // A load presents the new byte's first symbol in the same cycle it is captured.
    always_comb begin
        cur_reg   = load ? load_byte : shreg;
        cur_hold  = load ? '0 : hold;
        cur_idx   = load ? '0 : sym_idx;
        hold_last = (cur_hold == HW'(SYM_PIX - 1));
        sym_last  = (cur_idx == SW'(SYMS - 1));
        sym       = cur_reg[7 -: BPS];
        slot_last = (load || advance) && hold_last && sym_last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            hold    <= '0;
            sym_idx <= '0;
        end else if (load || advance) begin
            if (hold_last) begin
                shreg   <= cur_reg << BPS;
                hold    <= '0;
                sym_idx <= sym_last ? '0 : cur_idx + SW'(1);
            end else begin
                shreg   <= cur_reg;
                hold    <= cur_hold + HW'(1);
                sym_idx <= cur_idx;
            end
        end
    end

endmodule

// File: rtl/tape_video_encoder.sv
// Byte stream to line/frame structured composite video for the DAC.
// Optional feature macro: LINE_HEADER_EN (16-bit line index in the first two slots).
module tape_video_encoder
    import tape_video_pkg::*;
#(
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BLANK   = DEF_V_BLANK,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int BPS       = DEF_BPS,
    parameter int SYM_PIX   = DEF_SYM_PIX,
    parameter int BLANK_LVL = DEF_BLANK_LVL,
    parameter int BLACK_LVL = DEF_BLACK_LVL,
    parameter int STEP      = DEF_STEP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] video,
    output logic       sync_n,
    output logic       line_start,
    output logic       frame_start,
    output logic       underrun
);

    localparam int H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL     = V_SYNC + V_BLANK + V_ACTIVE;
    localparam int ACT_START   = H_SYNC + H_BACK;
    localparam int FRONT_START = ACT_START + H_ACTIVE;
    localparam int V_ACT_START = V_SYNC + V_BLANK;
    localparam int SLOT_PIX    = slot_pixels(BPS, SYM_PIX);
    localparam int SLOTS       = H_ACTIVE / SLOT_PIX;
    localparam int HW          = $clog2(H_TOTAL);
    localparam int VW          = $clog2(V_TOTAL);

    if (!(BPS == 1 || BPS == 2 || BPS == 4 || BPS == 8)) begin : g_bad_bps
        $error("tape_video_encoder: BPS must be 1, 2, 4 or 8");
    end
    if (SYM_PIX < 1) begin : g_bad_sym_pix
        $error("tape_video_encoder: SYM_PIX must be at least 1");
    end
    if (H_ACTIVE % SLOT_PIX != 0) begin : g_bad_active
        $error("tape_video_encoder: H_ACTIVE must be a multiple of a byte slot");
    end
    if (BLACK_LVL + STEP * ((1 << BPS) - 1) > 255) begin : g_bad_levels
        $error("tape_video_encoder: top symbol level exceeds the 8-bit DAC range");
    end
    if (H_SYNC < 1 || H_BACK < 1 || H_FRONT < 1) begin : g_bad_htiming
        $error("tape_video_encoder: sync and porch widths must be non-zero");
    end

    run_state_t    state;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          slot_next_q;

    phase_t        phase;
    line_type_t    ltype;
    logic          pix_valid;
    logic          last_h;
    logic          last_v;
    logic          act_px;
    logic          slot_start;
    logic          hdr_slot;
    logic [7:0]    hdr_byte;
    logic [7:0]    load_byte;
    logic [BPS-1:0] sym;
    logic          slot_last;
    logic [7:0]    pix_video;
    logic          pix_sync_n;

    // h/v name the pixel being computed this cycle; it reaches the pins next cycle.
    // Counters sit at 0 in IDLE, so en can start pixel 0 straight from IDLE.
    always_comb begin
        pix_valid = (state == ST_RUN) || en;
        last_h    = (h == HW'(H_TOTAL - 1));
        last_v    = (v == VW'(V_TOTAL - 1));

        phase = PH_FRONT;
        if (h < HW'(H_SYNC))           phase = PH_SYNC;
        else if (h < HW'(ACT_START))   phase = PH_BACK;
        else if (h < HW'(FRONT_START)) phase = PH_ACTIVE;

        ltype = LT_ACTIVE;
        if (v < VW'(V_SYNC))           ltype = LT_VSYNC;
        else if (v < VW'(V_ACT_START)) ltype = LT_BLANK;

        act_px     = pix_valid && (ltype == LT_ACTIVE) && (phase == PH_ACTIVE);
        slot_start = act_px && ((h == HW'(ACT_START)) || slot_next_q);
    end

`ifdef LINE_HEADER_EN
    localparam int SCW = $clog2(SLOTS + 1);

    if (SLOTS < HEADER_SLOTS) begin : g_bad_header
        $error("tape_video_encoder: line header needs at least two byte slots");
    end

    logic [SCW-1:0] slot_cnt_q;
    logic [SCW-1:0] cur_slot;
    logic [15:0]    line_idx;

    always_comb begin
        cur_slot = (h == HW'(ACT_START)) ? '0 : slot_cnt_q;
        line_idx = 16'(v) - 16'(V_ACT_START);
        hdr_slot = slot_start && (cur_slot < SCW'(HEADER_SLOTS));
        hdr_byte = (cur_slot == '0) ? line_idx[15:8] : line_idx[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            slot_cnt_q <= '0;
        else if (slot_start)
            slot_cnt_q <= cur_slot + SCW'(1);
    end
`else
    always_comb begin
        hdr_slot = 1'b0;
        hdr_byte = 8'h00;
    end
`endif

    // An unanswered slot loads zero, which is symbol 0 (black) for every pixel.
    always_comb begin
        in_ready  = slot_start && !hdr_slot;
        load_byte = hdr_slot ? hdr_byte : (in_valid ? in_data : 8'h00);
    end

    tape_symbol_shifter #(
        .BPS     (BPS),
        .SYM_PIX (SYM_PIX)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (slot_start),
        .advance   (act_px && !slot_start),
        .load_byte (load_byte),
        .sym       (sym),
        .slot_last (slot_last)
    );

    // VSYNC lines are inverted: sync low except for the trailing H_SYNC pixels.
    always_comb begin
        pix_video  = 8'(BLANK_LVL);
        pix_sync_n = 1'b1;
        case (ltype)
            LT_VSYNC: begin
                if (h < HW'(H_TOTAL - H_SYNC)) begin
                    pix_video  = 8'h00;
                    pix_sync_n = 1'b0;
                end
            end
            default: begin
                if (phase == PH_SYNC) begin
                    pix_video  = 8'h00;
                    pix_sync_n = 1'b0;
                end else if (ltype == LT_ACTIVE && phase == PH_ACTIVE) begin
                    pix_video = sym_level(8'(sym), 8'(BLACK_LVL), 8'(STEP));
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            h           <= '0;
            v           <= '0;
            slot_next_q <= 1'b0;
            video       <= 8'(BLANK_LVL);
            sync_n      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            slot_next_q <= slot_last;
            if (in_ready && !in_valid)
                underrun <= 1'b1;
            if (pix_valid) begin
                video       <= pix_video;
                sync_n      <= pix_sync_n;
                line_start  <= (h == '0);
                frame_start <= (h == '0) && (v == '0);
                if (last_h) begin
                    h <= '0;
                    v <= last_v ? '0 : v + VW'(1);
                end else begin
                    h <= h + HW'(1);
                end
                // en only matters on the final pixel of a frame.
                state <= (last_h && last_v && !en) ? ST_IDLE : ST_RUN;
            end else begin
                video       <= 8'(BLANK_LVL);
                sync_n      <= 1'b1;
                line_start  <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tape_video_encoder.sv
// Randomized self-checking bench for tape_video_encoder using a frame-position
// reference model; honours LINE_HEADER_EN when defined.
module tb_tape_video_encoder;

    localparam int H_SYNC = 4, H_BACK = 4, H_ACTIVE = 16, H_FRONT = 4;
    localparam int V_SYNC = 1, V_BLANK = 1, V_ACTIVE = 2;
    localparam int BPS = 2, SYM_PIX = 1;
    localparam int BLANK = 60, BLACK = 70, STEP = 61;
    localparam int H_TOT     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int FRAME_PIX = H_TOT * (V_SYNC + V_BLANK + V_ACTIVE);
    localparam int ACT0      = H_SYNC + H_BACK;
    localparam int V_ACT0    = V_SYNC + V_BLANK;
    localparam int SLOT_PIX  = SYM_PIX * (8 / BPS);
    localparam int CAP0      = V_ACT0 * H_TOT + ACT0;
`ifdef LINE_HEADER_EN
    localparam int HDR_SLOTS = 2;
`else
    localparam int HDR_SLOTS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] video;
    logic       sync_n;
    logic       line_start;
    logic       frame_start;
    logic       underrun;

    int         n_cmp  = 0;
    int         n_fail = 0;
    bit         exp_underrun;
    logic [7:0] slot_byte;
    logic [7:0] byte_q[$];
    logic [7:0] cap[8];

    tape_video_encoder #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
        .V_SYNC(V_SYNC), .V_BLANK(V_BLANK), .V_ACTIVE(V_ACTIVE),
        .BPS(BPS), .SYM_PIX(SYM_PIX),
        .BLANK_LVL(BLANK), .BLACK_LVL(BLACK), .STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .video(video), .sync_n(sync_n),
        .line_start(line_start), .frame_start(frame_start), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Slot index whose first pixel is frame pixel k+1, or -1 if none.
    function automatic int model_slot(input int k);
        int n, line, x;
        n = k + 1;
        if (n >= FRAME_PIX) return -1;
        line = n / H_TOT;
        x    = n % H_TOT;
        if (line < V_ACT0) return -1;
        if (x < ACT0 || x >= ACT0 + H_ACTIVE) return -1;
        if ((x - ACT0) % SLOT_PIX != 0) return -1;
        return (x - ACT0) / SLOT_PIX;
    endfunction

    // {sync_n, video} expected at frame pixel k when the current slot holds b.
    function automatic logic [8:0] model_pix(input int k, input logic [7:0] b);
        int line, x, j, s;
        line = k / H_TOT;
        x    = k % H_TOT;
        if (line < V_SYNC)
            return (x >= H_TOT - H_SYNC) ? {1'b1, 8'(BLANK)} : 9'd0;
        if (x < H_SYNC) return 9'd0;
        if (line >= V_ACT0 && x >= ACT0 && x < ACT0 + H_ACTIVE) begin
            j = ((x - ACT0) % SLOT_PIX) / SYM_PIX;
            s = (int'(b) >> (8 - BPS * (j + 1))) & ((1 << BPS) - 1);
            return {1'b1, 8'(BLACK + s * STEP)};
        end
        return {1'b1, 8'(BLANK)};
    endfunction

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        exp_underrun = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (video !== 8'd60) begin n_fail++; $display("[TB] FAIL reset_video got %0d want 60", video); end
        n_cmp++; if (sync_n !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_sync got %b want 1", sync_n); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready got %b want 0", in_ready); end
        n_cmp++; if (line_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ls got %b want 0", line_start); end
        n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fs got %b want 0", frame_start); end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_underrun got %b want 0", underrun); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (video !== 8'd60) begin n_fail++; $display("[TB] FAIL idle_video got %0d want 60", video); end
        n_cmp++; if (sync_n !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_sync got %b want 1", sync_n); end
    endtask

    // Runs n_frames from IDLE; en is released over the last frame's final cycles.
    task automatic test_stream(input int n_frames, input int valid_pct, input bit toggle_en,
                               input int abort_k, input int starve_k);
        int s, idx;
        bit rdy;
        logic [8:0] px;
        @(posedge clk); #1;
        en = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL start_ready got %b want 0", in_ready); end
        n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("[TB] FAIL start_fs got %b want 0", frame_start); end
        for (int f = 0; f < n_frames; f++) begin
            for (int k = 0; k < FRAME_PIX; k++) begin
                s   = model_slot(k);
                rdy = (s >= HDR_SLOTS);
                @(posedge clk); #1;
                in_valid = ($urandom_range(99) < valid_pct) && (k != starve_k);
                in_data  = (rdy && byte_q.size() > 0) ? byte_q[0] : 8'($urandom);
                en = (toggle_en && k < FRAME_PIX - 3) ? 1'($urandom_range(1)) : (f < n_frames - 1);
                if (f == 0 && k == abort_k) begin
                    rst = 1'b0; en = 1'b0;
                    #1;
                    n_cmp++; if (video !== 8'd60) begin n_fail++; $display("[TB] FAIL abort_video got %0d want 60", video); end
                    n_cmp++; if (sync_n !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_sync got %b want 1", sync_n); end
                    n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_underrun got %b want 0", underrun); end
                    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_ready got %b want 0", in_ready); end
                    @(posedge clk); #1;
                    n_cmp++; if (video !== 8'd60) begin n_fail++; $display("[TB] FAIL abort_edge_video got %0d want 60", video); end
                    n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_edge_fs got %b want 0", frame_start); end
                    rst = 1'b1;
                    exp_underrun = 1'b0;
                    return;
                end
                @(negedge clk);
                px = model_pix(k, slot_byte);
                n_cmp++; if (video !== px[7:0]) begin n_fail++; $display("[TB] FAIL video f=%0d k=%0d got %0d want %0d", f, k, video, px[7:0]); end
                n_cmp++; if (sync_n !== px[8]) begin n_fail++; $display("[TB] FAIL sync_n f=%0d k=%0d got %b want %b", f, k, sync_n, px[8]); end
                n_cmp++; if (in_ready !== rdy) begin n_fail++; $display("[TB] FAIL in_ready f=%0d k=%0d got %b want %b", f, k, in_ready, rdy); end
                n_cmp++; if (line_start !== (k % H_TOT == 0)) begin n_fail++; $display("[TB] FAIL line_start f=%0d k=%0d got %b", f, k, line_start); end
                n_cmp++; if (frame_start !== (k == 0)) begin n_fail++; $display("[TB] FAIL frame_start f=%0d k=%0d got %b", f, k, frame_start); end
                n_cmp++; if (underrun !== exp_underrun) begin n_fail++; $display("[TB] FAIL underrun f=%0d k=%0d got %b want %b", f, k, underrun, exp_underrun); end
                if (f == 0 && k >= CAP0 && k < CAP0 + 8) cap[k - CAP0] = video;
                if (s >= 0) begin
                    if (s < HDR_SLOTS) begin
                        idx = (k + 1) / H_TOT - V_ACT0;
                        slot_byte = (s == 0) ? 8'(idx >> 8) : 8'(idx & 255);
                    end else if (in_valid) begin
                        slot_byte = in_data;
                        if (byte_q.size() > 0) void'(byte_q.pop_front());
                    end else begin
                        slot_byte = 8'h00;
                        exp_underrun = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            en = 1'b0;
            @(negedge clk);
            n_cmp++; if (video !== 8'd60) begin n_fail++; $display("[TB] FAIL tail_video i=%0d got %0d want 60", i, video); end
            n_cmp++; if (sync_n !== 1'b1) begin n_fail++; $display("[TB] FAIL tail_sync i=%0d got %b want 1", i, sync_n); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL tail_ready i=%0d got %b want 0", i, in_ready); end
            n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("[TB] FAIL tail_fs i=%0d got %b want 0", i, frame_start); end
        end
    endtask

    task automatic test_known_bytes();
        logic [7:0] want[8];
`ifdef LINE_HEADER_EN
        want = '{8'd70, 8'd70, 8'd70, 8'd70, 8'd70, 8'd70, 8'd70, 8'd70};
`else
        want = '{8'd70, 8'd131, 8'd192, 8'd253, 8'd253, 8'd192, 8'd131, 8'd70};
`endif
        byte_q = '{8'h1B, 8'hE4};
        test_stream(2, 100, 1'b0, -1, -1);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (cap[i] !== want[i]) begin
                n_fail++; $display("[TB] FAIL first_line_pix%0d got %0d want %0d", i, cap[i], want[i]);
            end
        end
        byte_q.delete();
    endtask

    task automatic test_underrun();
        test_stream(1, 100, 1'b0, -1, V_ACT0 * H_TOT + ACT0 + 2 * SLOT_PIX - 1);
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("[TB] FAIL underrun_sticky got %b want 1", underrun); end
    endtask

    task automatic test_reset_midline();
        test_stream(1, 70, 1'b0, V_ACT0 * H_TOT + ACT0 + 5, -1);
        test_stream(1, 100, 1'b0, -1, -1);
    endtask

    task automatic test_back_to_back();
        test_stream(3, 75, 1'b1, -1, -1);
    endtask

    initial begin
        slot_byte = 8'h00;
        test_reset();
        test_known_bytes();
        test_underrun();
        test_reset_midline();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
